regfile_scoreboard: RTL and testbench
=====================================

# regfile_scoreboard

Parametrised two-read/one-write register file with a per-register pending-write scoreboard. It is the next generation of the datapath register file: width, depth and R0 behaviour are configurable, and it adds write-to-read bypass plus busy tracking for in-flight destination registers. It sits between decode (reads, issue) and writeback (write port) of the pipelined datapath. Decode uses it to detect RAW hazards without a separate hazard table.

## Interface
- DATA_W, 32, register data width in bits.
- NREGS, 32, number of registers; power of two, 2..64.
- AW, log2(NREGS), register-address width (derived, not overridden).
- ZERO_R0, 1, 1 = register 0 reads as 0, ignores writes and is never marked busy.
- BYPASS, 1, 1 = a same-cycle write is forwarded to the read ports.
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- ra, rb  in  AW each  read-port register numbers.
- pa, pb  out  DATA_W each  read data; combinational (asynchronous read).
- pa_busy, pb_busy  out  1 each  register addressed by ra/rb has a write pending.
- rw  in  AW  writeback register number.
- pw  in  DATA_W  writeback data.
- le  in  1  write enable; writes on the rising edge when high.
- iss_en  in  1  decode issues an instruction that will write iss_rd.
- iss_rd  in  AW  destination register of the issuing instruction.
- iss_ready  out  1  iss_rd may be issued this cycle (combinational).
- iss_err  out  1  sticky: an issue was attempted while iss_ready was 0.
- busy_cnt  out  AW+1  registered count of busy registers.

## Operation
- Storage: NREGS x DATA_W flops plus NREGS busy bits.
- Read, port A (port B is identical with rb): pa = 0 if ZERO_R0 and ra==0; otherwise pw if BYPASS, le, rw==ra and the write is effective; otherwise regs[ra].
- pa_busy = busy[ra] && !(BYPASS && le && rw==ra). pa_busy is always 0 for r0 when ZERO_R0.
- Write: on a rising edge with le=1, regs[rw] <= pw. The write is dropped when ZERO_R0 and rw==0.
- Busy clear: an effective write to rw clears busy[rw] on the same edge. A write to a non-busy register is legal and leaves the register not busy.
- Issue: iss_ready = !busy[iss_rd] || (le && rw==iss_rd). When ZERO_R0 and iss_rd==0, iss_ready=1 and the issue has no effect.
- Busy set: iss_en && iss_ready sets busy[iss_rd] on the edge.
- Simultaneous set and clear on the same register: set wins, so busy stays 1 and belongs to the new owner.
- Refused issue: iss_en && !iss_ready changes no busy bit and sets iss_err; only reset clears iss_err.
- busy_cnt: next-state popcount of the busy bits, registered, so it always equals the number of set busy bits after each edge.

## Timing
- Reset (rst_n low, asynchronous assertion):
  - all registers 0, all busy bits 0, busy_cnt=0, iss_err=0;
  - pa=pb=0 and pa_busy=pb_busy=0 while rst_n is low;
  - le and iss_en are ignored while rst_n is low.
- Reset release: the first edge with rst_n high performs normal operation.
- Read latency: 0 cycles (combinational from ra/rb, rw/pw/le and state).
- Write latency: the data is visible through regs on the cycle after the edge. With BYPASS=1 it is already visible in the write cycle; with BYPASS=0 it is not.
- Busy latency: a set or clear is visible on pa_busy/iss_ready/busy_cnt the cycle after the edge.
- Reset mid-operation: pending busy bits are discarded and in-flight writes are lost.
- Boundaries:
  - busy_cnt maximum is NREGS-1 (ZERO_R0=1) or NREGS (ZERO_R0=0); it never wraps.
  - rw==ra==rb is forwarded to both ports simultaneously.

## Test plan
- Reset/R0: release reset, read all 32 regs -> all 0. Write r0=0xDEADBEEF (ZERO_R0=1) -> r0 still reads 0, busy_cnt=0.
- Write/read: write r5=0x12345678, next cycle ra=5, rb=5 -> pa=pb=0x12345678. With BYPASS=1 and ra=5 during the write cycle, pa=0x12345678 in that cycle; with BYPASS=0, pa=old value (0).
- Scoreboard: issue r7 -> next cycle pa_busy=1 for ra=7, busy_cnt=1. Writeback r7=0xA5 -> pa_busy=0 in the write cycle (BYPASS=1), busy_cnt=0 on the next cycle.
- Hazard: issue r9, then issue r9 again with no write -> iss_ready=0, iss_err=1, busy_cnt stays 1. Issue r9 in the same cycle as le=1, rw=9 -> accepted, busy[9] stays 1, busy_cnt=1.
- Fill: issue r1..r31 on consecutive cycles -> busy_cnt=31. Clear them all -> busy_cnt=0.
- Async reset mid-operation: with 3 registers busy and r3=0x55, pulse rst_n low between edges -> busy_cnt, iss_err and pa drop to 0 immediately, r3 reads 0 after release.

Source files
------------

// File: rtl/regfile_scoreboard.sv
// Two-read/one-write register file with write-to-read bypass and a
// per-register pending-write scoreboard for RAW hazard detection at decode.
module regfile_scoreboard #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned NREGS   = 32,
  parameter bit          ZERO_R0 = 1'b1,
  parameter bit          BYPASS  = 1'b1,
  localparam int unsigned AW     = $clog2(NREGS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [AW-1:0]     ra,
  input  logic [AW-1:0]     rb,
  output logic [DATA_W-1:0] pa,
  output logic [DATA_W-1:0] pb,
  output logic              pa_busy,
  output logic              pb_busy,
  input  logic [AW-1:0]     rw,
  input  logic [DATA_W-1:0] pw,
  input  logic              le,
  input  logic              iss_en,
  input  logic [AW-1:0]     iss_rd,
  output logic              iss_ready,
  output logic              iss_err,
  output logic [AW:0]       busy_cnt
);

  localparam int unsigned CW = AW + 1;

  logic [DATA_W-1:0] regs [NREGS];
  logic [NREGS-1:0]  busy;
  logic [NREGS-1:0]  busy_nxt;
  logic [CW-1:0]     cnt_nxt;
  logic              we;
  logic              iss_set;

  // Effective write: r0 writes are dropped when it is hardwired to zero
  assign we = le && !(ZERO_R0 && rw == '0);

  // Read port A: zero register, then same-cycle forward, then storage
  always_comb begin
    pa = regs[ra];
    if (!rst_n)                        pa = '0;
    else if (ZERO_R0 && ra == '0)      pa = '0;
    else if (BYPASS && we && rw == ra) pa = pw;
  end

  // Read port B: same structure as port A
  always_comb begin
    pb = regs[rb];
    if (!rst_n)                        pb = '0;
    else if (ZERO_R0 && rb == '0)      pb = '0;
    else if (BYPASS && we && rw == rb) pb = pw;
  end

  // Busy flags seen by readers; a forwarded write hides the pending state
  always_comb begin
    pa_busy = rst_n && busy[ra] && !(BYPASS && le && rw == ra);
    pb_busy = rst_n && busy[rb] && !(BYPASS && le && rw == rb);
  end

  // Issue acceptance: free, being written back now, or the zero register
  always_comb begin
    iss_ready = !busy[iss_rd] || (le && rw == iss_rd) || (ZERO_R0 && iss_rd == '0);
    iss_set   = iss_en && iss_ready && !(ZERO_R0 && iss_rd == '0);
  end

  // Next busy vector (set overrides clear) and its population count
  always_comb begin
    busy_nxt = busy;
    if (we)      busy_nxt[rw]     = 1'b0;
    if (iss_set) busy_nxt[iss_rd] = 1'b1;
    cnt_nxt = '0;
    for (int i = 0; i < NREGS; i++) begin
      cnt_nxt = cnt_nxt + CW'(busy_nxt[i]);
    end
  end

  // Register storage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) begin
        regs[i] <= '0;
      end
    end else if (we) begin
      regs[rw] <= pw;
    end
  end

  // Scoreboard state, busy count and sticky refused-issue flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy     <= '0;
      busy_cnt <= '0;
      iss_err  <= 1'b0;
    end else begin
      busy     <= busy_nxt;
      busy_cnt <= cnt_nxt;
      if (iss_en && !iss_ready) iss_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed bench for regfile_scoreboard; a second BYPASS=0 instance shares inputs.
module tb_regfile_scoreboard;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [4:0]  ra, rb, rw, iss_rd;
  logic [31:0] pw;
  logic        le, iss_en;

  logic [31:0] pa, pb, nb_pa, nb_pb;
  logic        pa_busy, pb_busy, nb_pa_busy, nb_pb_busy;
  logic        iss_ready, iss_err, nb_iss_ready, nb_iss_err;
  logic [5:0]  busy_cnt, nb_busy_cnt;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  regfile_scoreboard #(.DATA_W(32), .NREGS(32), .ZERO_R0(1'b1), .BYPASS(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .ra(ra), .rb(rb), .pa(pa), .pb(pb),
    .pa_busy(pa_busy), .pb_busy(pb_busy), .rw(rw), .pw(pw), .le(le),
    .iss_en(iss_en), .iss_rd(iss_rd), .iss_ready(iss_ready),
    .iss_err(iss_err), .busy_cnt(busy_cnt)
  );

  regfile_scoreboard #(.DATA_W(32), .NREGS(32), .ZERO_R0(1'b1), .BYPASS(1'b0)) dut_nb (
    .clk(clk), .rst_n(rst_n), .ra(ra), .rb(rb), .pa(nb_pa), .pb(nb_pb),
    .pa_busy(nb_pa_busy), .pb_busy(nb_pb_busy), .rw(rw), .pw(pw), .le(le),
    .iss_en(iss_en), .iss_rd(iss_rd), .iss_ready(nb_iss_ready),
    .iss_err(nb_iss_err), .busy_cnt(nb_busy_cnt)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    le = 1'b0; iss_en = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; ra = '0; rb = '0; rw = '0; pw = '0; iss_rd = '0; idle();
    #3;
    n_cmp++; if (busy_cnt !== 6'd0) begin n_fail++; $display("FAIL reset_busy_cnt got %0d want 0", busy_cnt); end
    n_cmp++; if (iss_err !== 1'b0) begin n_fail++; $display("FAIL reset_iss_err got %b want 0", iss_err); end
    n_cmp++; if (pa !== 32'h0 || pa_busy !== 1'b0) begin n_fail++; $display("FAIL reset_pa got %h/%b want 0/0", pa, pa_busy); end
    tick();
    rst_n = 1'b1;
    tick();
    for (int i = 0; i < 32; i++) begin
      ra = 5'(i); rb = 5'(31 - i); #1;
      n_cmp++; if (pa !== 32'h0 || pb !== 32'h0) begin n_fail++; $display("FAIL reset_read r%0d got %h/%h want 0", i, pa, pb); end
    end
    // r0 write must be dropped, both in the write cycle and afterwards
    ra = 5'd0; rw = 5'd0; pw = 32'hDEADBEEF; le = 1'b1; #1;
    n_cmp++; if (pa !== 32'h0) begin n_fail++; $display("FAIL r0_bypass got %h want 0", pa); end
    tick(); idle(); #1;
    n_cmp++; if (pa !== 32'h0) begin n_fail++; $display("FAIL r0_write got %h want 0", pa); end
    n_cmp++; if (busy_cnt !== 6'd0) begin n_fail++; $display("FAIL r0_busy_cnt got %0d want 0", busy_cnt); end
  endtask

  task automatic test_write_read();
    ra = 5'd5; rb = 5'd5; rw = 5'd5; pw = 32'h12345678; le = 1'b1; #1;
    n_cmp++; if (pa !== 32'h12345678 || pb !== 32'h12345678) begin n_fail++; $display("FAIL bypass_both got %h/%h want 12345678", pa, pb); end
    n_cmp++; if (nb_pa !== 32'h0) begin n_fail++; $display("FAIL nobypass_old got %h want 0", nb_pa); end
    tick(); idle(); #1;
    n_cmp++; if (pa !== 32'h12345678 || pb !== 32'h12345678) begin n_fail++; $display("FAIL read_after_write got %h/%h want 12345678", pa, pb); end
    n_cmp++; if (nb_pa !== 32'h12345678) begin n_fail++; $display("FAIL nobypass_after got %h want 12345678", nb_pa); end
    rb = 5'd6; #1;
    n_cmp++; if (pb !== 32'h0) begin n_fail++; $display("FAIL other_reg got %h want 0", pb); end
  endtask

  task automatic test_scoreboard();
    iss_en = 1'b1; iss_rd = 5'd7; ra = 5'd7; #1;
    n_cmp++; if (iss_ready !== 1'b1) begin n_fail++; $display("FAIL sb_ready got %b want 1", iss_ready); end
    n_cmp++; if (pa_busy !== 1'b0) begin n_fail++; $display("FAIL sb_busy_issue_cycle got %b want 0", pa_busy); end
    tick(); idle(); #1;
    n_cmp++; if (pa_busy !== 1'b1 || busy_cnt !== 6'd1) begin n_fail++; $display("FAIL sb_busy got %b/%0d want 1/1", pa_busy, busy_cnt); end
    le = 1'b1; rw = 5'd7; pw = 32'hA5; #1;
    n_cmp++; if (pa_busy !== 1'b0 || pa !== 32'hA5) begin n_fail++; $display("FAIL sb_wb_cycle got %b/%h want 0/a5", pa_busy, pa); end
    n_cmp++; if (nb_pa_busy !== 1'b1) begin n_fail++; $display("FAIL sb_nb_busy got %b want 1", nb_pa_busy); end
    n_cmp++; if (busy_cnt !== 6'd1) begin n_fail++; $display("FAIL sb_cnt_wb_cycle got %0d want 1", busy_cnt); end
    tick(); idle(); #1;
    n_cmp++; if (busy_cnt !== 6'd0 || pa_busy !== 1'b0) begin n_fail++; $display("FAIL sb_cleared got %0d/%b want 0/0", busy_cnt, pa_busy); end
  endtask

  task automatic test_hazard();
    iss_en = 1'b1; iss_rd = 5'd9; tick();
    #1;
    n_cmp++; if (iss_ready !== 1'b0) begin n_fail++; $display("FAIL hz_ready got %b want 0", iss_ready); end
    tick(); idle(); #1;
    n_cmp++; if (iss_err !== 1'b1) begin n_fail++; $display("FAIL hz_err got %b want 1", iss_err); end
    n_cmp++; if (busy_cnt !== 6'd1) begin n_fail++; $display("FAIL hz_cnt got %0d want 1", busy_cnt); end
    // Re-issue in the writeback cycle: accepted, stays busy for the new owner
    iss_en = 1'b1; iss_rd = 5'd9; le = 1'b1; rw = 5'd9; pw = 32'h99; ra = 5'd9; #1;
    n_cmp++; if (iss_ready !== 1'b1) begin n_fail++; $display("FAIL hz_same_cycle_ready got %b want 1", iss_ready); end
    tick(); idle(); #1;
    n_cmp++; if (pa_busy !== 1'b1 || busy_cnt !== 6'd1 || pa !== 32'h99) begin n_fail++; $display("FAIL hz_set_wins got %b/%0d/%h want 1/1/99", pa_busy, busy_cnt, pa); end
    le = 1'b1; rw = 5'd9; pw = 32'h9A; tick(); idle(); #1;
    n_cmp++; if (busy_cnt !== 6'd0 || iss_err !== 1'b1) begin n_fail++; $display("FAIL hz_sticky got %0d/%b want 0/1", busy_cnt, iss_err); end
  endtask

  task automatic test_fill();
    iss_en = 1'b1; iss_rd = 5'd0; #1;
    n_cmp++; if (iss_ready !== 1'b1) begin n_fail++; $display("FAIL fill_r0_ready got %b want 1", iss_ready); end
    tick();
    n_cmp++; if (busy_cnt !== 6'd0) begin n_fail++; $display("FAIL fill_r0_noop got %0d want 0", busy_cnt); end
    for (int i = 1; i < 32; i++) begin
      iss_en = 1'b1; iss_rd = 5'(i); tick();
    end
    idle(); ra = 5'd31; rb = 5'd0; #1;
    n_cmp++; if (busy_cnt !== 6'd31) begin n_fail++; $display("FAIL fill_cnt got %0d want 31", busy_cnt); end
    n_cmp++; if (pa_busy !== 1'b1 || pb_busy !== 1'b0) begin n_fail++; $display("FAIL fill_busy got %b/%b want 1/0", pa_busy, pb_busy); end
    for (int i = 1; i < 32; i++) begin
      le = 1'b1; rw = 5'(i); pw = 32'(i) + 32'h100; tick();
    end
    idle(); #1;
    n_cmp++; if (busy_cnt !== 6'd0) begin n_fail++; $display("FAIL drain_cnt got %0d want 0", busy_cnt); end
    n_cmp++; if (pa !== 32'h11F) begin n_fail++; $display("FAIL drain_data got %h want 11f", pa); end
  endtask

  task automatic test_async_reset();
    le = 1'b1; rw = 5'd3; pw = 32'h55; tick(); idle();
    for (int i = 1; i <= 3; i++) begin
      iss_en = 1'b1; iss_rd = 5'(i); tick();
    end
    idle(); ra = 5'd3; #1;
    n_cmp++; if (busy_cnt !== 6'd3 || pa !== 32'h55) begin n_fail++; $display("FAIL pre_reset got %0d/%h want 3/55", busy_cnt, pa); end
    rst_n = 1'b0; #2;
    n_cmp++; if (busy_cnt !== 6'd0 || iss_err !== 1'b0 || pa !== 32'h0) begin n_fail++; $display("FAIL async_reset got %0d/%b/%h want 0/0/0", busy_cnt, iss_err, pa); end
    #1 rst_n = 1'b1;
    tick();
    n_cmp++; if (pa !== 32'h0 || pa_busy !== 1'b0 || busy_cnt !== 6'd0) begin n_fail++; $display("FAIL post_reset got %h/%b/%0d want 0/0/0", pa, pa_busy, busy_cnt); end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_scoreboard();
    test_hazard();
    test_fill();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
